// File: rtl/seqdet_param.sv
// Runtime-programmable serial pattern detector with overlap control,
// input qualifier and saturating match counter.
module seqdet_param #(
    parameter int unsigned        PAT_W   = 8,
    parameter int unsigned        CNT_W   = 8,
    parameter logic [PAT_W-1:0]   RST_PAT = PAT_W'(8'b0000_1011),
    parameter int unsigned        RST_LEN = 4,
    parameter bit                 RST_OVL = 1'b1,
    localparam int unsigned       LEN_W   = $clog2(PAT_W + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    input  logic               din_vld,
    input  logic               cfg_we,
    input  logic [PAT_W-1:0]   cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic             r_match;
    logic [CNT_W-1:0] r_cnt;

    logic [PAT_W-1:0] w_hist_n;
    logic [LEN_W-1:0] w_fill_n;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W-1:0] w_len_clamp;
    logic             w_hit;

    // Next history/fill, active-length compare mask and hit detection.
    always_comb begin
        w_hist_n    = {r_hist[PAT_W-2:0], din};
        w_fill_n    = (r_fill >= LEN_W'(PAT_W)) ? r_fill : r_fill + LEN_W'(1);
        w_mask      = '0;
        w_len_clamp = cfg_len;
        w_hit       = 1'b0;
        for (int i = 0; i < PAT_W; i++) begin
            if (LEN_W'(i) < r_len) begin
                w_mask[i] = 1'b1;
            end
        end
        if (cfg_len == '0) begin
            w_len_clamp = LEN_W'(1);
        end else if (cfg_len > LEN_W'(PAT_W)) begin
            w_len_clamp = LEN_W'(PAT_W);
        end
        // A config write discards the bit presented in the same cycle.
        if (din_vld && !cfg_we && (w_fill_n >= r_len) &&
            (((w_hist_n ^ r_pat) & w_mask) == '0)) begin
            w_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= RST_PAT;
            r_len   <= LEN_W'(RST_LEN);
            r_ovl   <= RST_OVL;
            r_match <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (cfg_we) begin
                r_pat   <= cfg_pattern;
                r_len   <= w_len_clamp;
                r_ovl   <= cfg_ovl;
                r_hist  <= '0;
                r_fill  <= '0;
                r_match <= 1'b0;
            end else if (din_vld) begin
                r_hist  <= w_hist_n;
                // Non-overlapping mode restarts the fill so consumed bits cannot be reused.
                r_fill  <= (w_hit && !r_ovl) ? '0 : w_fill_n;
                r_match <= w_hit;
            end else begin
                r_match <= 1'b0;
            end

            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_hit && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign match     = r_match;
    assign match_cnt = r_cnt;

endmodule
